// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-stream instruction loader that assembles MSB-first words into instruction memory
module program_loader #(
  parameter int MEM_DEPTH = 800,
  parameter int BASE_ADDR = 0
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [9:0]  WordCount,
  input  logic [7:0]  ByteIn,
  input  logic        ByteValid,
  output logic        ByteReady,
  output logic        WriteEnable,
  output logic [31:0] WriteAddress,
  output logic [31:0] WriteData,
  output logic        Busy,
  output logic        Done,
  output logic        Error,
  output logic [7:0]  Checksum
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RECEIVE = 3'd1;
  localparam logic [2:0] S_WRITE   = 3'd2;
  localparam logic [2:0] S_DONE    = 3'd3;
  localparam logic [2:0] S_ERROR   = 3'd4;

  localparam logic [31:0] BASE_W = BASE_ADDR;
  localparam logic [31:0] MEM_W  = MEM_DEPTH;

  logic [2:0]  state_q, state_d;
  logic [9:0]  idx_q, idx_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;
  logic [9:0]  wc_q, wc_d;
  logic [7:0]  sum_q, sum_d;
  logic [31:0] waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        bad_count;

  // Range check is done in 32 bits so BASE_ADDR+WordCount cannot wrap.
  assign bad_count = (WordCount == 10'd0) || ((BASE_W + {22'd0, WordCount}) > MEM_W);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    wc_d    = wc_q;
    sum_d   = sum_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (Start) begin
          if (bad_count) begin
            state_d = S_ERROR;
          end else begin
            state_d = S_RECEIVE;
            idx_d   = 10'd0;
            cnt_d   = 2'd0;
            sum_d   = 8'd0;
            wc_d    = WordCount;
          end
        end
      end
      S_RECEIVE: begin
        if (ByteValid) begin
          word_d = {word_q[23:0], ByteIn};
          sum_d  = sum_q + ByteIn;
          cnt_d  = cnt_q + 2'd1;
          // Address and data are captured here so they hold once WRITE ends.
          if (cnt_q == 2'd3) begin
            state_d = S_WRITE;
            waddr_d = BASE_W + {22'd0, idx_q};
            wdata_d = {word_q[23:0], ByteIn};
          end
        end
      end
      S_WRITE: begin
        if (idx_q == wc_q - 10'd1) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 10'd1;
          state_d = S_RECEIVE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      idx_q   <= 10'd0;
      cnt_q   <= 2'd0;
      word_q  <= 32'd0;
      wc_q    <= 10'd0;
      sum_q   <= 8'd0;
      waddr_q <= 32'd0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      wc_q    <= wc_d;
      sum_q   <= sum_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign ByteReady    = (state_q == S_RECEIVE);
  assign WriteEnable  = (state_q == S_WRITE);
  assign Busy         = (state_q == S_RECEIVE) || (state_q == S_WRITE);
  assign Done         = (state_q == S_DONE);
  assign Error        = (state_q == S_ERROR);
  assign WriteAddress = waddr_q;
  assign WriteData    = wdata_q;
  assign Checksum     = sum_q;

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have parameter MEM_DEPTH, default 800, giving the number of instruction memory words.
REQ-002 The block SHALL have parameter BASE_ADDR, default 0, giving the first word address written.
REQ-003 Port Clock  input  1  single clock; all state updates on posedge Clock.
REQ-004 Port Reset  input  1  synchronous, active-high reset.
REQ-005 Port Start  input  1  load request, sampled on posedge Clock.
REQ-006 Port WordCount  input  10  number of 32-bit words to load; latched when Start is accepted.
REQ-007 Port ByteIn  input  8  program stream byte.
REQ-008 Port ByteValid  input  1  ByteIn is valid.
REQ-009 Port ByteReady  output  1  loader accepts a byte this cycle.
REQ-010 Port WriteEnable  output  1  instruction memory write strobe.
REQ-011 Port WriteAddress  output  32  instruction memory word address.
REQ-012 Port WriteData  output  32  assembled instruction word.
REQ-013 Port Busy  output  1  load in progress; the processor is held while high.
REQ-014 Port Done  output  1  the last load completed successfully.
REQ-015 Port Error  output  1  the last Start was rejected.
REQ-016 Port Checksum  output  8  modulo-256 sum of the bytes accepted since the last accepted Start.

Function
REQ-017 The block SHALL implement the states IDLE, RECEIVE, WRITE, DONE and ERROR.
REQ-018 When Start=1 in IDLE, DONE or ERROR, the block SHALL reject the load and go to ERROR if WordCount==0 or BASE_ADDR+WordCount>MEM_DEPTH; otherwise it SHALL go to RECEIVE.
REQ-019 On entry to RECEIVE from Start, the block SHALL clear the word index, byte count, Checksum, Done and Error, and SHALL latch WordCount.
REQ-020 In RECEIVE, ByteReady SHALL be 1; in every other state, ByteReady SHALL be 0.
REQ-021 A byte SHALL be accepted only on a posedge where ByteValid=1 and ByteReady=1; idle gaps on ByteValid SHALL be tolerated with no state change.
REQ-022 Accepted bytes SHALL be assembled MSB-first (shift register {word[23:0], ByteIn}), and each accepted byte SHALL be added to Checksum with 8-bit wrap.
REQ-023 Acceptance of the 4th byte of a word SHALL move the block to WRITE on the same edge.
REQ-024 WRITE SHALL last exactly one cycle, with WriteEnable=1, WriteData=assembled word and WriteAddress=BASE_ADDR+word index (zero-extended to 32 bits).
REQ-025 The write SHALL occur the cycle after the 4th byte is accepted (1-cycle latency).
REQ-026 After WRITE, the block SHALL go to DONE if word index==latched WordCount-1; otherwise it SHALL increment the word index and return to RECEIVE.
REQ-027 Outside WRITE, WriteEnable SHALL be 0, and WriteAddress/WriteData SHALL hold their last values.
REQ-028 Busy SHALL be 1 exactly in RECEIVE and WRITE.
REQ-029 Done SHALL be 1 in DONE, and Error SHALL be 1 in ERROR.
REQ-030 Done and Error SHALL be sticky until the next accepted Start or Reset.
REQ-031 Start SHALL be ignored while Busy=1, and WordCount changes after the latch SHALL have no effect.
REQ-032 Checksum SHALL hold its value in DONE and ERROR.
REQ-033 Bytes presented in IDLE, DONE or ERROR SHALL not be consumed.

Reset
REQ-034 While Reset=1 at posedge Clock, the block SHALL enter IDLE and clear the word index, byte count and assembly register.
REQ-035 On reset, the outputs SHALL take the values ByteReady=0, WriteEnable=0, WriteAddress=0, WriteData=0, Busy=0, Done=0, Error=0, Checksum=0.
REQ-036 Reset SHALL take priority over Start and ByteValid.
REQ-037 Reset during RECEIVE SHALL discard the partial word and SHALL produce no write.
REQ-038 Reset during WRITE SHALL suppress the write; WriteEnable SHALL be 0 on the cycle following the reset edge.

Verification
REQ-039 Single word: Start, WordCount=1, bytes 0x1B,0xE0,0x00,0x00 -> one WriteEnable pulse, WriteAddress=0, WriteData=0x1BE00000, Checksum=0xFB, Done=1, Busy=0.
REQ-040 Three words with ByteValid gaps of 0-3 cycles -> writes to addresses 0,1,2 in order, each word correct, exactly 3 WriteEnable pulses.
REQ-041 Rejection: WordCount=0 -> Error=1 with no writes; WordCount=801 -> Error=1 with ByteReady never asserted; a following valid Start clears Error.
REQ-042 Boundary: WordCount=800 -> last write at WriteAddress=799, then Done=1; a 3201st byte offered -> not accepted.
REQ-043 Reset after 2 bytes of word 1 -> IDLE, no WriteEnable, all outputs at reset values; a restart then loads correctly from address 0.
REQ-044 Start pulsed mid-load with a different WordCount -> ignored; the original count completes.
